// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types for the pipeline controller. This file holds the
//               FSM state encoding, the register-index width, and the packed
//               bundle of pipeline control outputs with its named values.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int STATE_W = 2;
  localparam int REG_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  // Control bundle; field order is fixed so the named values below line up
  typedef struct packed {
    logic pc_we;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exmem_hold;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF     = 7'b000_0000;
  localparam ctrl_t CTRL_NORMAL  = 7'b100_0000;
  localparam ctrl_t CTRL_BRANCH  = 7'b101_0000;
  localparam ctrl_t CTRL_LOADUSE = 7'b010_0100;
  localparam ctrl_t CTRL_FREEZE  = 7'b010_1011;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundle of hazard/memory status inputs and stall/flush outputs
//               that pass between the datapath (master) and the pipeline
//               controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
  import pipeline_pkg::*;

  logic               idex_memread_i;
  logic [REG_W-1:0]   idex_rd_i;
  logic [REG_W-1:0]   ifid_rs1_i;
  logic [REG_W-1:0]   ifid_rs2_i;
  logic               branch_taken_i;
  logic               dmem_req_i;
  logic               dmem_ready_i;

  logic               pc_we_o;
  logic               ifid_hold_o;
  logic               ifid_flush_o;
  logic               idex_hold_o;
  logic               idex_flush_o;
  logic               exmem_hold_o;
  logic               memwb_flush_o;
  logic [STATE_W-1:0] state_o;
  logic               err_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    input  pc_we_o, ifid_hold_o, ifid_flush_o, idex_hold_o, idex_flush_o,
           exmem_hold_o, memwb_flush_o, state_o, err_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    output pc_we_o, ifid_hold_o, ifid_flush_o, idex_hold_o, idex_flush_o,
           exmem_hold_o, memwb_flush_o, state_o, err_o
  );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard compare. A load in ID/EX whose
//               destination register (not x0) is read by the instruction in
//               IF/ID raises the hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  output logic             hazard_o
);

  // x0 is hardwired to zero, so a load into it never creates a dependency
  always_comb begin
    hazard_o = idex_memread_i && (idex_rd_i != '0) &&
               ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall/flush controller. It freezes the pipeline on a
//               data-memory wait, with a timeout into a sticky error state. It
//               stalls one cycle on a load-use hazard and flushes IF/ID on a
//               taken branch.
//               Optional build macro PIPE_PERF_CNT_EN adds saturating stall
//               and flush cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipeline_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  // Wide enough to hold MEM_TIMEOUT itself
  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              hazard;
  logic              run_rules;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread_i (bus.idex_memread_i),
    .idex_rd_i      (bus.idex_rd_i),
    .ifid_rs1_i     (bus.ifid_rs1_i),
    .ifid_rs2_i     (bus.ifid_rs2_i),
    .hazard_o       (hazard)
  );

  // Next state, wait counter and the control bundle for this cycle
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    ctrl      = CTRL_NORMAL;
    run_rules = 1'b0;

    unique case (state_q)
      ST_RUN: run_rules = 1'b1;
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready_i) begin
          ctrl   = CTRL_FREEZE;
          wcnt_d = wcnt_q + WCNT_ONE;
          if (wcnt_d >= WCNT_LIMIT) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else begin
          // Access completes: release immediately and behave as RUN
          state_d   = ST_RUN;
          wcnt_d    = '0;
          run_rules = 1'b1;
        end
      end
      ST_ERR: ctrl = CTRL_FREEZE;
      default: begin
        state_d = ST_RUN;
        ctrl    = CTRL_FREEZE;
      end
    endcase

    // RUN priority: memory wait, then load-use, then taken branch
    if (run_rules) begin
      if (bus.dmem_req_i && !bus.dmem_ready_i) begin
        ctrl    = CTRL_FREEZE;
        wcnt_d  = WCNT_ONE;
        state_d = ST_MEM_WAIT;
        if (WCNT_ONE >= WCNT_LIMIT) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end else if (hazard) begin
        ctrl = CTRL_LOADUSE;
      end else if (bus.branch_taken_i) begin
        ctrl = CTRL_BRANCH;
      end
    end

    // Everything is quiet while reset is held, independent of the clock
    if (!rst_i) begin
      ctrl = CTRL_OFF;
    end
  end

  // State, wait counter and sticky error flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_we_o       = ctrl.pc_we;
  assign bus.ifid_hold_o   = ctrl.ifid_hold;
  assign bus.ifid_flush_o  = ctrl.ifid_flush;
  assign bus.idex_hold_o   = ctrl.idex_hold;
  assign bus.idex_flush_o  = ctrl.idex_flush;
  assign bus.exmem_hold_o  = ctrl.exmem_hold;
  assign bus.memwb_flush_o = ctrl.memwb_flush;
  assign bus.state_o       = state_q;
  assign bus.err_o         = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counts of stalled-PC cycles and IF/ID flush cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ctrl.ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule : pipeline_ctrl
`default_nettype wire
